// File: rtl/alu_operand_regfile.sv
// Register file feeding the ALU operands: r0 hardwired to zero, sequential clear sweep after reset.
// Optional write-through forwarding to the read ports is enabled by defining REGFILE_WRITE_BYPASS_EN.
module alu_operand_regfile #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wrEn,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [DATA_W-1:0] wrData,
    input  logic [ADDR_W-1:0] rdAddr1,
    input  logic [ADDR_W-1:0] rdAddr2,
    output logic [DATA_W-1:0] rdData1,
    output logic [DATA_W-1:0] rdData2,
    output logic              ready
);

    typedef enum logic {CLEAR, RUN} stateT;

    // clrCnt carries one extra bit so the terminal compare never aliases on wrap
    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(NUM_REGS - 1);

    stateT             state;
    stateT             stateNext;
    logic [ADDR_W:0]   clrCnt;
    logic [ADDR_W:0]   clrCntNext;
    logic              readyNext;
    logic [DATA_W-1:0] regs [NUM_REGS];

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= CLEAR;
            clrCnt <= '0;
            ready  <= 1'b0;
        end else begin
            state  <= stateNext;
            clrCnt <= clrCntNext;
            ready  <= readyNext;
        end
    end

    always_comb begin
        stateNext  = state;
        clrCntNext = clrCnt;
        readyNext  = ready;
        case (state)
            CLEAR: begin
                clrCntNext = clrCnt + (ADDR_W+1)'(1);
                if (clrCnt == LAST_IDX) begin
                    stateNext = RUN;
                    readyNext = 1'b1;
                end
            end
            RUN: begin
                stateNext = RUN;
            end
            default: begin
                stateNext = CLEAR;
            end
        endcase
    end

    // Register contents are left alone on reset edges; the sweep clears them afterwards
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == CLEAR) begin
                regs[clrCnt[ADDR_W-1:0]] <= '0;
            end else if (wrEn && (wrAddr != '0)) begin
                regs[wrAddr] <= wrData;
            end
        end
    end

    always_comb begin
        rdData1 = '0;
        rdData2 = '0;
        if ((state == RUN) && !reset) begin
            if (rdAddr1 != '0) rdData1 = regs[rdAddr1];
            if (rdAddr2 != '0) rdData2 = regs[rdAddr2];
`ifdef REGFILE_WRITE_BYPASS_EN
            if (wrEn && (wrAddr != '0) && (rdAddr1 == wrAddr)) rdData1 = wrData;
            if (wrEn && (wrAddr != '0) && (rdAddr2 == wrAddr)) rdData2 = wrData;
`endif
        end
    end

endmodule

// File: doc/alu_operand_regfile.md
Name: alu_operand_regfile

Overview:
- Architectural register file directly upstream of the ALU.
- Supplies the two 32-bit ALU operands combinationally and accepts the write-back result one clock edge later.
- Register 0 is a hardwired zero.
- After reset, a sequential clear sweep zeroes every register one per cycle. The block reports ready only when the sweep is complete, which gates the processor out of reset.

Parameters:
DATA_W, 32, width of each register and read/write data
NUM_REGS, 16, number of architectural registers (power of two, >= 2)
ADDR_W, 4, register address width, log2(NUM_REGS)

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
wrEn  in  1  write enable for write-back port
wrAddr  in  ADDR_W  write-back register index
wrData  in  DATA_W  write-back data (ALU dataOut or memory data)
rdAddr1  in  ADDR_W  read port 1 index (feeds ALU data1)
rdAddr2  in  ADDR_W  read port 2 index (feeds ALU data2)
rdData1  out  DATA_W  read port 1 data
rdData2  out  DATA_W  read port 2 data
ready  out  1  high when the clear sweep is done and the file is usable

Behaviour:
- Reset: one clock, clk, with a synchronous active-high reset named reset.
  - Edge with reset=1: state<=CLEAR, clrCnt<=0, ready<=0. Register contents are not touched on that edge.
- States are CLEAR and RUN.
- CLEAR:
  - Each edge with reset=0: regs[clrCnt]<=0 and clrCnt<=clrCnt+1.
  - On the edge where clrCnt==NUM_REGS-1: state<=RUN, ready<=1.
  - ready therefore rises on the NUM_REGS-th edge after reset is released (16 by default).
  - wrEn is ignored throughout CLEAR.
  - rdData1/rdData2 = 0 throughout CLEAR and while reset=1.
- RUN:
  - Edge with wrEn=1 and wrAddr!=0: regs[wrAddr]<=wrData.
  - A write to register 0 is discarded.
  - RUN holds until reset.
- Reads (RUN):
  - Combinational, zero latency: rdDataN = (rdAddrN==0) ? 0 : regs[rdAddrN].
  - Both ports may address the same register; both return the same value.
- Read/write same register, same cycle: reads return the pre-edge (old) value; the new value is visible after the edge, unless the Optional Feature is enabled.
- Reset mid-sweep: the sweep restarts from clrCnt=0 and ready stays 0.
- Reset in RUN: ready falls on that edge and the full sweep repeats.
- clrCnt is ADDR_W+1 bits so the terminal compare never aliases on wrap.
- Output reset values: ready=0, rdData1=0, rdData2=0.
- No X propagation: registers never read before the sweep writes them.

Optional Feature:
- Macro: REGFILE_WRITE_BYPASS_EN.
- Defined: in RUN, if wrEn=1, wrAddr!=0 and rdAddrN==wrAddr, rdDataN = wrData combinationally in the same cycle (write-through forwarding). The register update at the edge is unchanged. Register 0 still reads 0.
- Undefined: no forwarding; same-cycle reads return the old value.
- Neither setting changes CLEAR behaviour.

Test Plan:
- Reset sweep: hold reset 3 cycles, release, drive wrEn=1 wrAddr=5 wrData=32'hDEADBEEF every cycle.
  - Required: ready=0 for exactly 15 edges and rises on the 16th.
  - Required: reading r5 afterwards returns 0, because writes are ignored in CLEAR.
- Basic write/read: in RUN write r3=32'h00000007, r4=32'hFFFFFFF9.
  - Required: rdAddr1=3, rdAddr2=4 give 7 and 0xFFFFFFF9 next cycle; rdAddr1=rdAddr2=3 gives 7 on both.
- Zero register: write r0=32'h12345678.
  - Required: rdData1 at rdAddr1=0 stays 0 in all cycles.
- Same-cycle read/write: r9 holds 0x11; wrEn=1 wrAddr=9 wrData=0x22 with rdAddr1=9.
  - Required: rdData1=0x11 that cycle and 0x22 after the edge.
  - With REGFILE_WRITE_BYPASS_EN defined: 0x22 in the same cycle.
- Reset mid-sweep: assert reset for 1 cycle at sweep cycle 8.
  - Required: ready remains 0 and rises exactly 16 edges after this release.
- Reset in RUN: fill r1..r15 with index values, then pulse reset.
  - Required: ready falls on that edge; after ready returns, every register reads 0.
